mem_access_arbiter: RTL and testbench

Sequencing controller that shares the single `Main_Memory` port between the instruction-fetch path and the data load/store path of the CPU datapath. It accepts level requests from both requesters, grants one at a time, and drives the memory's `read`/`write`/`instruction` controls and address/data until the memory's `done` is seen. It then returns read data with a one-cycle acknowledge. It also enforces fairness between the two requesters and guards against a hung memory with a timeout.

---
 rtl/mem_access_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_access_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// Latency: grant the cycle after the request, ack the cycle after mem_done or timeout.
// Backpressure: requests are level-held until ack; one access at a time, fetch protected from starvation.
module mem_access_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 13,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_instruction,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DREAD,
    S_DWRITE,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic [7:0]        r_wait_cnt;
  logic [3:0]        r_starve_cnt;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_instruction;

  logic       w_starve_full;
  logic       w_grant_fetch;
  logic [7:0] w_wait_next;
  logic       w_timeout;

  // Fetch wins when alone, or when data has already taken its quota of back-to-back grants.
  assign w_starve_full = (r_starve_cnt == 4'(STARVE_LIMIT));
  assign w_grant_fetch = if_req && (!d_req || w_starve_full);
  // r_wait_cnt counts completed active cycles; the current one brings it to w_wait_next,
  // so the abort fires at the end of the TIMEOUT-th active cycle.
  assign w_wait_next   = r_wait_cnt + 8'd1;
  assign w_timeout     = (w_wait_next == 8'(TIMEOUT));

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_IDLE;
      r_owner_d         <= 1'b0;
      r_wait_cnt        <= '0;
      r_starve_cnt      <= '0;
      r_if_ack          <= 1'b0;
      r_d_ack           <= 1'b0;
      r_err             <= 1'b0;
      r_rdata           <= '0;
      r_mem_addr        <= '0;
      r_mem_din         <= '0;
      r_mem_read        <= 1'b0;
      r_mem_write       <= 1'b0;
      r_mem_instruction <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait_cnt <= '0;
          if (w_grant_fetch) begin
            r_state           <= S_FETCH;
            r_owner_d         <= 1'b0;
            r_mem_addr        <= if_addr;
            r_mem_read        <= 1'b1;
            r_mem_instruction <= 1'b1;
            r_starve_cnt      <= '0;
          end else if (d_req) begin
            r_owner_d  <= 1'b1;
            r_mem_addr <= d_addr;
            if (d_we) begin
              r_state     <= S_DWRITE;
              r_mem_write <= 1'b1;
              r_mem_din   <= d_wdata;
            end else begin
              r_state    <= S_DREAD;
              r_mem_read <= 1'b1;
            end
            if (!if_req) begin
              r_starve_cnt <= '0;
            end else if (!w_starve_full) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
          end
        end
        S_FETCH, S_DREAD, S_DWRITE: begin
          if (mem_done || w_timeout) begin
            r_state           <= S_RESP;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_instruction <= 1'b0;
            r_if_ack          <= !r_owner_d;
            r_d_ack           <= r_owner_d;
            r_err             <= !mem_done;
            if (mem_done && (r_state != S_DWRITE)) begin
              r_rdata <= mem_dout;
            end
          end else begin
            r_wait_cnt <= w_wait_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ack          = r_if_ack;
  assign d_ack           = r_d_ack;
  assign err             = r_err;
  assign rdata           = r_rdata;
  assign mem_addr        = r_mem_addr;
  assign mem_din         = r_mem_din;
  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_instruction = r_mem_instruction;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: vector table of single accesses, then fairness,
// timeout and mid-access reset sequences; acks are scored against a queue.
module tb_mem_access_arbiter;

  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [12:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [12:0] d_addr;
  logic [12:0] d_wdata;
  logic        d_ack;
  logic [12:0] rdata;
  logic        err;
  logic [12:0] mem_addr;
  logic [12:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic        mem_instruction;
  logic [12:0] mem_dout;
  logic        mem_done;

  mem_access_arbiter #(
    .ADDR_W(13), .DATA_W(13), .TIMEOUT(TMO), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_write(mem_write), .mem_instruction(mem_instruction),
    .mem_dout(mem_dout), .mem_done(mem_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [12:0] addr;
    logic [12:0] wdata;
    logic [12:0] dout;
    int          lat;        // active cycles before mem_done; -1 = never
    int          ack_cyc;    // cycle of ack, counting first active cycle as 1
    logic [12:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [12:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic        overlap_seen = 1'b0;
  logic        stray_err    = 1'b0;
  logic [12:0] model_rdata  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (mem_read && mem_write) overlap_seen = 1'b1;
    if (err && !(if_ack || d_ack)) stray_err = 1'b1;
    if (if_ack || d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(1), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_both", {31'd0, if_ack && d_ack}, 32'(0));
        chk("ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
        chk("ack_rdata", {19'd0, rdata}, {19'd0, e.rdata});
        chk("ack_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   n;
    logic bad;
    exp_t e;
    logic exp_rd, exp_wr, exp_in;
    exp_rd = !(v.is_d && v.we);
    exp_wr = v.is_d && v.we;
    exp_in = !v.is_d;
    if_req  = !v.is_d;
    d_req   = v.is_d;
    d_we    = v.we;
    if_addr = v.is_d ? ~v.addr : v.addr;
    d_addr  = v.is_d ? v.addr : ~v.addr;
    d_wdata = v.wdata;
    e.is_d = v.is_d; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    tick();
    n = 1;
    chk("grant_ctrl", {29'd0, mem_read, mem_write, mem_instruction},
        {29'd0, exp_rd, exp_wr, exp_in});
    chk("grant_addr", {19'd0, mem_addr}, {19'd0, v.addr});
    if (exp_wr) chk("grant_din", {19'd0, mem_din}, {19'd0, v.wdata});
    bad = 1'b0;
    while (!(if_ack || d_ack) && n <= 40) begin
      if ({mem_read, mem_write, mem_instruction} !== {exp_rd, exp_wr, exp_in} ||
          mem_addr !== v.addr) bad = 1'b1;
      mem_done = (v.lat >= 0) && (n == 1 + v.lat);
      mem_dout = v.dout;
      tick();
      n++;
    end
    mem_done = 1'b0;
    if_req   = 1'b0;
    d_req    = 1'b0;
    chk("ctrl_stable", {31'd0, bad}, 32'(0));
    chk("ack_latency", 32'(n), 32'(v.ack_cyc));
    chk("resp_ctrl_low", {29'd0, mem_read, mem_write, mem_instruction}, 32'(0));
    tick();
    chk("idle_gap", {27'd0, mem_read, mem_write, mem_instruction, if_ack, d_ack}, 32'(0));
    model_rdata = v.exp_rdata;
  endtask

  // Both requesters held high; stores for data, fetch returns 13'h0F0F,
  // memory completes in the first active cycle. Records grant order.
  task automatic run_both(input int ngr, input bit abort_last, output string ord);
    int   cyc, got;
    logic act, prev_act;
    exp_t e;
    ord = ""; got = 0; prev_act = 1'b0; cyc = 0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 13'h0200; d_addr = 13'h0300; d_wdata = 13'h0123;
    mem_dout = 13'h0F0F;
    while (cyc < 200) begin
      tick();
      cyc++;
      act = mem_read | mem_write;
      if (act && !prev_act) begin
        got++;
        if (mem_instruction) ord = {ord, "F"};
        else ord = {ord, "D"};
        if (abort_last && got == ngr) break;
        e.is_d = !mem_instruction;
        if (mem_instruction) model_rdata = 13'h0F0F;
        e.rdata = model_rdata;
        e.err = 1'b0;
        sb.push_back(e);
      end
      mem_done = act;
      prev_act = act;
      if (!abort_last && got == ngr && (if_ack || d_ack)) break;
    end
    mem_done = 1'b0;
    if (!abort_last) begin
      if_req = 1'b0;
      d_req  = 1'b0;
      tick();
    end
  endtask

  vec_t  vecs[7];
  string ord;

  initial begin
    vecs[0] = '{is_d:1'b0, we:1'b0, addr:13'h0040, wdata:13'h0000, dout:13'h1ABC,
                lat:2, ack_cyc:4, exp_rdata:13'h1ABC, exp_err:1'b0};
    vecs[1] = '{is_d:1'b1, we:1'b1, addr:13'h0100, wdata:13'h0055, dout:13'h0999,
                lat:1, ack_cyc:3, exp_rdata:13'h1ABC, exp_err:1'b0};
    vecs[2] = '{is_d:1'b1, we:1'b0, addr:13'h0123, wdata:13'h1111, dout:13'h0777,
                lat:0, ack_cyc:2, exp_rdata:13'h0777, exp_err:1'b0};
    vecs[3] = '{is_d:1'b0, we:1'b0, addr:13'h1FFF, wdata:13'h0000, dout:13'h1FFF,
                lat:3, ack_cyc:5, exp_rdata:13'h1FFF, exp_err:1'b0};
    vecs[4] = '{is_d:1'b1, we:1'b0, addr:13'h0AAA, wdata:13'h0000, dout:13'h0555,
                lat:-1, ack_cyc:TMO+1, exp_rdata:13'h1FFF, exp_err:1'b1};
    vecs[5] = '{is_d:1'b0, we:1'b0, addr:13'h0002, wdata:13'h0000, dout:13'h0001,
                lat:0, ack_cyc:2, exp_rdata:13'h0001, exp_err:1'b0};
    vecs[6] = '{is_d:1'b1, we:1'b1, addr:13'h0BEE, wdata:13'h1234, dout:13'h0666,
                lat:-1, ack_cyc:TMO+1, exp_rdata:13'h0001, exp_err:1'b1};

    reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_dout = '0; mem_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_ctrl", {29'd0, mem_read, mem_write, mem_instruction}, 32'(0));
    chk("rst_acks", {29'd0, if_ack, d_ack, err}, 32'(0));
    chk("rst_rdata", {19'd0, rdata}, 32'(0));
    chk("rst_addr", {19'd0, mem_addr}, 32'(0));
    chk("rst_din", {19'd0, mem_din}, 32'(0));

    // mem_done while idle must be ignored
    mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    chk("idle_done_ignored", {27'd0, mem_read, mem_write, mem_instruction, if_ack, d_ack}, 32'(0));
    tick();
    chk("idle_done_no_ack", {30'd0, if_ack, d_ack}, 32'(0));

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Fairness with both requests held continuously
    run_both(10, 1'b0, ord);
    chk("starve_order", (ord == "DDDDFDDDDF") ? 32'(1) : 32'(0), 32'(1));
    if (ord != "DDDDFDDDDF") $display("  grant order got %s", ord);

    // Three data grants, then reset during the fourth (a store)
    run_both(4, 1'b1, ord);
    chk("pre_abort_order", (ord == "DDDD") ? 32'(1) : 32'(0), 32'(1));
    chk("abort_in_write", {31'd0, mem_write}, 32'(1));
    reset = 1'b1;
    tick();
    chk("abort_write_low", {29'd0, mem_read, mem_write, mem_instruction}, 32'(0));
    chk("abort_no_ack", {30'd0, if_ack, d_ack}, 32'(0));
    chk("abort_rdata_clr", {19'd0, rdata}, 32'(0));
    reset = 1'b0;
    model_rdata = '0;
    run_both(5, 1'b0, ord);
    chk("post_reset_order", (ord == "DDDDF") ? 32'(1) : 32'(0), 32'(1));

    tick(); tick();
    chk("sb_drained", 32'(sb.size()), 32'(0));
    chk("rd_wr_overlap", {31'd0, overlap_seen}, 32'(0));
    chk("err_without_ack", {31'd0, stray_err}, 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
